// File: rtl/ar_add_gate.sv
// Bit-serial AR add gate: adds the intermediate bus into the recirculating AR word, LSB first.
// Optional framing check enabled by defining AR_ADD_SYNC_CHECK_EN.
module ar_add_gate (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       IB,
    input  logic       AR_IN,
    input  logic       T0,
    input  logic       TS,
    input  logic       ADD,
    input  logic       IS,
    output logic       LB,
    output logic       CY,
    output logic       ACT,
    output logic       OVFLW,
    output logic [4:0] BIT_CNT,
    output logic       SYNC_ERR
);

    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(28);

    logic             addw;
    logic             cin;
    logic             act_d;
    logic             cy_d;
    logic             ovf_d;
    logic [CNT_W-1:0] cnt_d;

    // Serial full adder; reset forces pass-through of IB.
    always_comb begin
        addw  = rst & (T0 ? ADD : ACT);
        cin   = T0 ? (ADD & IS) : CY;
        LB    = addw ? (IB ^ AR_IN ^ cin) : IB;
        cy_d  = addw & ~TS & ((IB & AR_IN) | (IB & cin) | (AR_IN & cin));
        ovf_d = TS & addw & (IB ~^ AR_IN) & (LB ^ IB);
        act_d = T0 ? ADD : ACT;
        if (T0) begin
            cnt_d = CNT_W'(1);
        end else if (BIT_CNT == LAST_BIT) begin
            cnt_d = '0;
        end else begin
            cnt_d = BIT_CNT + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            CY      <= 1'b0;
            ACT     <= 1'b0;
            OVFLW   <= 1'b0;
            BIT_CNT <= '0;
        end else begin
            CY      <= cy_d;
            ACT     <= act_d;
            OVFLW   <= ovf_d;
            BIT_CNT <= cnt_d;
        end
    end

`ifdef AR_ADD_SYNC_CHECK_EN
    logic t0_seen;
    logic sync_err_q;
    logic frame_bad;

    // The first T0 after reset aligns the counter and is never a framing error.
    always_comb begin
        frame_bad = (TS & ~T0 & (BIT_CNT != LAST_BIT)) |
                    (T0 & t0_seen & (BIT_CNT != '0));
    end

    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            t0_seen    <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            t0_seen    <= t0_seen | T0;
            sync_err_q <= sync_err_q | frame_bad;
        end
    end

    assign SYNC_ERR = sync_err_q;
`else
    assign SYNC_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ar_add_gate.sv
// Scoreboard bench for ar_add_gate: word-level reference model, bit-serial stimulus.
module tb_ar_add_gate;

    logic       CLOCK;
    logic       rst;
    logic       IB, AR_IN, T0, TS, ADD, IS;
    logic       LB, CY, ACT, OVFLW, SYNC_ERR;
    logic [4:0] BIT_CNT;

    ar_add_gate dut (
        .CLOCK(CLOCK), .rst(rst), .IB(IB), .AR_IN(AR_IN), .T0(T0), .TS(TS),
        .ADD(ADD), .IS(IS), .LB(LB), .CY(CY), .ACT(ACT), .OVFLW(OVFLW),
        .BIT_CNT(BIT_CNT), .SYNC_ERR(SYNC_ERR)
    );

    typedef struct {
        logic [28:0] lb;
        logic        ovf;
        logic        add;
    } exp_t;

    localparam logic [28:0] MASK = 29'h1FFF_FFFF;

`ifdef AR_ADD_SYNC_CHECK_EN
    localparam logic SE_EXP = 1'b1;
`else
    localparam logic SE_EXP = 1'b0;
`endif

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Two's-complement word add; sign is bit 28, its carry-out is dropped.
    function automatic exp_t model(input logic [28:0] ib, input logic [28:0] ar,
                                   input logic add, input logic is);
        exp_t        e;
        logic [29:0] s;
        s     = 30'(ib) + 30'(ar) + 30'(add & is);
        e.add = add;
        e.lb  = add ? s[28:0] : ib;
        e.ovf = add && (ib[28] == ar[28]) && (s[28] != ib[28]);
        return e;
    endfunction

    // mid_mode 0: ADD/IS random after T0; 1: ADD low until bit 10, then high.
    task automatic send_word(input logic [28:0] ib, input logic [28:0] ar,
                             input logic add, input logic is, input int mid_mode);
        q.push_back(model(ib, ar, add, is));
        for (int k = 0; k < 29; k++) begin
            @(posedge CLOCK);
            #1;
            T0    = (k == 0);
            TS    = (k == 28);
            IB    = ib[k];
            AR_IN = ar[k];
            if (k == 0) begin
                ADD = add;
                IS  = is;
            end else if (mid_mode == 1) begin
                ADD = (k >= 10);
                IS  = 1'b0;
            end else begin
                ADD = 1'($urandom_range(0, 1));
                IS  = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic drive_idle();
        @(posedge CLOCK);
        #1;
        T0 = 1'b0; TS = 1'b0; ADD = 1'b0; IS = 1'b0;
    endtask

    // Monitor: reassembles each LB word and checks per-bit state against the popped expectation.
    int          idx     = 0;
    logic        in_word = 1'b0;
    logic        ovf_exp = 1'b0;
    logic        cy_chk  = 1'b0;
    logic [28:0] lb_acc  = '0;
    exp_t        cur;

    always @(negedge CLOCK) begin
        if (mon_en) begin
            chk("ovflw", 32'(OVFLW), 32'(ovf_exp));
            ovf_exp = 1'b0;
            if (cy_chk) chk("cy_after_ts", 32'(CY), 32'd0);
            cy_chk = 1'b0;
            chk("sync_err_clean", 32'(SYNC_ERR), 32'd0);
            if (T0) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got word expected none");
                    cur = '{lb: '0, ovf: 1'b0, add: 1'b0};
                end else begin
                    cur = q.pop_front();
                end
                in_word = 1'b1;
                idx     = 0;
            end
            if (in_word) begin
                lb_acc[idx] = LB;
                if (idx > 0) begin
                    chk("bit_cnt", 32'(BIT_CNT), 32'(idx));
                    chk("act", 32'(ACT), 32'(cur.add));
                end
                if (idx == 28) begin
                    chk("lb_word", 32'(lb_acc), 32'(cur.lb));
                    ovf_exp = cur.ovf;
                    cy_chk  = 1'b1;
                    in_word = 1'b0;
                end
                idx++;
            end
        end
    end

    initial begin
        rst = 1'b0;
        T0 = 1'b1; TS = 1'b0; ADD = 1'b1; IS = 1'b1; IB = 1'b0; AR_IN = 1'b1;
        #3;
        chk("rst_cy", 32'(CY), 32'd0);
        chk("rst_act", 32'(ACT), 32'd0);
        chk("rst_ovflw", 32'(OVFLW), 32'd0);
        chk("rst_bit_cnt", 32'(BIT_CNT), 32'd0);
        chk("rst_sync_err", 32'(SYNC_ERR), 32'd0);
        chk("rst_lb_pass0", 32'(LB), 32'd0);
        IB = 1'b1; AR_IN = 1'b0;
        #1;
        chk("rst_lb_pass1", 32'(LB), 32'd1);
        repeat (3) @(posedge CLOCK);
        #1;
        chk("rst_hold_act", 32'(ACT), 32'd0);
        T0 = 1'b0; ADD = 1'b0; IS = 1'b0;
        @(negedge CLOCK);
        rst    = 1'b1;
        mon_en = 1'b1;

        send_word(29'd5, 29'd3, 1'b1, 1'b0, 0);
        send_word(~29'd3 & MASK, 29'd5, 1'b1, 1'b1, 0);
        send_word(29'h0FFF_FFFF, 29'd1, 1'b1, 1'b0, 0);
        send_word(29'($urandom) & MASK, 29'($urandom) & MASK, 1'b0, 1'b0, 1);
        send_word(29'h1000_0000, 29'h1000_0000, 1'b1, 1'b0, 0);
        for (int w = 0; w < 30; w++) begin
            send_word(29'($urandom) & MASK, 29'($urandom) & MASK,
                      1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 0);
        end
        drive_idle();
        @(negedge CLOCK);
        @(negedge CLOCK);
        mon_en = 1'b0;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        // Framing: second T0 arrives at bit 15.
        #2 rst = 1'b0;
        #3 rst = 1'b1;
        @(posedge CLOCK);
        #1;
        T0 = 1'b1; ADD = 1'b1; IS = 1'b0; IB = 1'b0; AR_IN = 1'b0;
        for (int k = 1; k < 15; k++) begin
            @(posedge CLOCK);
            #1;
            T0 = 1'b0;
        end
        @(posedge CLOCK);
        #1;
        T0 = 1'b1;
        @(negedge CLOCK);
        chk("sync_bit_cnt15", 32'(BIT_CNT), 32'd15);
        chk("sync_before", 32'(SYNC_ERR), 32'd0);
        drive_idle();
        @(negedge CLOCK);
        chk("sync_set", 32'(SYNC_ERR), 32'(SE_EXP));
        chk("sync_act", 32'(ACT), 32'd1);
        repeat (4) drive_idle();
        @(negedge CLOCK);
        chk("sync_sticky", 32'(SYNC_ERR), 32'(SE_EXP));
        IB = 1'b1; AR_IN = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("async_cy", 32'(CY), 32'd0);
        chk("async_act", 32'(ACT), 32'd0);
        chk("async_ovflw", 32'(OVFLW), 32'd0);
        chk("async_bit_cnt", 32'(BIT_CNT), 32'd0);
        chk("async_sync_err", 32'(SYNC_ERR), 32'd0);
        chk("async_lb", 32'(LB), 32'd1);

        // Mid-word release: idle until T0 even with ADD high.
        @(posedge CLOCK);
        #2 rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge CLOCK);
            #1;
            T0 = 1'b0; TS = 1'b0; ADD = 1'b1;
            IB = 1'($urandom_range(0, 1)); AR_IN = 1'($urandom_range(0, 1));
            @(negedge CLOCK);
            chk("idle_act", 32'(ACT), 32'd0);
            chk("idle_lb", 32'(LB), 32'(IB));
            chk("idle_bit_cnt", 32'(BIT_CNT), 32'(k + 1));
        end

        // T0 and TS together: T0 sets ACT/count/CIN, TS governs CY/OVFLW.
        @(posedge CLOCK);
        #1;
        T0 = 1'b1; TS = 1'b1; ADD = 1'b1; IS = 1'b0; IB = 1'b1; AR_IN = 1'b1;
        @(negedge CLOCK);
        chk("t0ts_lb", 32'(LB), 32'd0);
        drive_idle();
        @(negedge CLOCK);
        chk("t0ts_act", 32'(ACT), 32'd1);
        chk("t0ts_bit_cnt", 32'(BIT_CNT), 32'd1);
        chk("t0ts_cy", 32'(CY), 32'd0);
        chk("t0ts_ovflw", 32'(OVFLW), 32'd1);
        chk("t0ts_sync_err", 32'(SYNC_ERR), 32'd0);
        drive_idle();
        @(negedge CLOCK);
        chk("t0ts_ovflw_pulse", 32'(OVFLW), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
